// File: rtl/fir_pkg.sv
// Shared widths and sample types for the FIR output chain.
package fir_pkg;

    localparam int unsigned FIR_IN_WIDTH  = 32;
    localparam int unsigned FIR_OUT_WIDTH = 16;

    typedef logic signed [FIR_IN_WIDTH-1:0]  fir_in_t;
    typedef logic signed [FIR_OUT_WIDTH-1:0] fir_out_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit to tell full from empty.
// rd_data reads 0 while the FIFO is empty.
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = FIR_OUT_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fir_decim_requant.sv
// Decimate, requantize (shift + saturate) and buffer FIR accumulator samples.
// Define FIR_DECIM_ROUND_EN to round half toward +inf instead of truncating.
module fir_decim_requant
    import fir_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = FIR_IN_WIDTH,
    parameter int unsigned OUT_WIDTH  = FIR_OUT_WIDTH,
    parameter int unsigned SHIFT      = 15,
    parameter int unsigned DECIM      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    input  logic                        in_valid,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sat_flag,
    output logic                        drop_pulse
);

    localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned EW = IN_WIDTH + 1;

    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [EW-1:0]        ONE     = EW'(1);
    localparam logic signed [EW-1:0] RND     = ONE << (SHIFT - 1);

    logic [PW-1:0]                phase;
    logic                         keep;
    logic signed [EW-1:0]         ext;
    logic signed [EW-1:0]         shifted;
    logic                         sat_hi;
    logic                         sat_lo;
    logic signed [OUT_WIDTH-1:0]  q_next;
    logic signed [OUT_WIDTH-1:0]  q_data;
    logic                         q_valid;
    logic                         fifo_full;
    logic                         fifo_empty;

    assign keep = in_valid && (phase == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (in_valid) begin
            phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
        end
    end

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        ext = {in_data[IN_WIDTH-1], in_data};
`ifdef FIR_DECIM_ROUND_EN
        ext = ext + RND;
`endif
        shifted = ext >>> SHIFT;
        sat_hi  = (shifted > SAT_MAX);
        sat_lo  = (shifted < SAT_MIN);
        if (sat_hi)      q_next = SAT_MAX[OUT_WIDTH-1:0];
        else if (sat_lo) q_next = SAT_MIN[OUT_WIDTH-1:0];
        else             q_next = shifted[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid  <= 1'b0;
            q_data   <= '0;
            sat_flag <= 1'b0;
        end else begin
            q_valid <= keep;
            if (keep) q_data <= q_next;
            if (keep && (sat_hi || sat_lo)) sat_flag <= 1'b1;
        end
    end

    fir_sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (q_valid),
        .wr_data (q_data),
        .pop     (out_ready),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    // Full implies non-empty, so out_ready alone decides whether a pop frees a slot.
    assign drop_pulse = q_valid && fifo_full && !out_ready;

endmodule
